// File: rtl/sw_history_reader_pkg.sv
// Shared constants and sizing helpers for the switch-history read buffer.
// Imported by the top module and the seven-segment decoder.
package sw_history_reader_pkg;

    localparam int DW_DEF    = 10;
    localparam int DEPTH_DEF = 8;
    localparam int POP_W     = 4;

    typedef logic [6:0] seg_t;

    // Pointer width for a power-of-two buffer depth.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Fill count needs one extra bit so that "full" (== depth) is representable.
    function automatic int cnt_w(input int depth);
        return ptr_w(depth) + 1;
    endfunction

endpackage

// File: rtl/dectohex.sv
// Nibble to seven-segment decoder, segments active-low, bit order {g,f,e,d,c,b,a}.
module dectohex
    import sw_history_reader_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    // Hex glyph lookup.
    always_comb begin
        seg = 7'h7F;
        case (nibble)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/sw_history_reader.sv
// FIFO of captured switch words, popped one per read strobe onto the LEDs,
// with fill level and pop count shown on two seven-segment digits.
module sw_history_reader
    import sw_history_reader_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk100_i,
    input  logic          rst_i,
    input  logic          wr_en_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_req_i,
    output logic [DW-1:0] ledr_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          ovf_o,
    output logic          udf_o,
    output logic [6:0]    hex1_o,
    output logic [6:0]    hex0_o
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [DW-1:0]    mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    wr_ptr_nxt_s;
    logic [PW-1:0]    rd_ptr_nxt_s;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nxt_s;
    logic [POP_W-1:0] pop_r;
    logic [DW-1:0]    ledr_r;
    logic             ovf_r;
    logic             udf_r;
    logic             full_s;
    logic             empty_s;
    logic             rd_acc_s;
    logic             wr_acc_s;

    // Acceptance decisions: a read frees a slot, so a write into a full buffer is legal alongside it.
    always_comb begin
        full_s   = (count_r == CNT_FULL);
        empty_s  = (count_r == {CW{1'b0}});
        rd_acc_s = rd_req_i & ~empty_s;
        wr_acc_s = wr_en_i & (~full_s | rd_acc_s);
    end

    // Next pointers and fill count.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        if (wr_acc_s) begin
            wr_ptr_nxt_s = (wr_ptr_r == PTR_LAST) ? {PW{1'b0}} : wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (rd_acc_s) begin
            rd_ptr_nxt_s = (rd_ptr_r == PTR_LAST) ? {PW{1'b0}} : rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_nxt_s = count_r + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_nxt_s = count_r - {{(CW-1){1'b0}}, 1'b1};
            default: count_nxt_s = count_r;
        endcase
    end

    // Control state, LED word and sticky error flags.
    always_ff @(posedge clk100_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            pop_r    <= {POP_W{1'b0}};
            ledr_r   <= {DW{1'b0}};
            ovf_r    <= 1'b0;
            udf_r    <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            if (rd_acc_s) begin
                ledr_r <= mem_r[rd_ptr_r];
                pop_r  <= pop_r + 4'd1;
            end else begin
                ledr_r <= ledr_r;
                pop_r  <= pop_r;
            end
            ovf_r <= ovf_r | (wr_en_i & ~wr_acc_s);
            udf_r <= udf_r | (rd_req_i & ~rd_acc_s);
        end
    end

    // Storage array; contents are don't-care after reset so it carries no reset.
    always_ff @(posedge clk100_i) begin
        if (wr_acc_s) begin
            mem_r[wr_ptr_r] <= wr_data_i;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    assign ledr_o  = ledr_r;
    assign full_o  = full_s;
    assign empty_o = empty_s;
    assign ovf_o   = ovf_r;
    assign udf_o   = udf_r;

    dectohex u_hex_fill (
        .nibble (4'(count_r)),
        .seg    (hex1_o)
    );

    dectohex u_hex_pop (
        .nibble (pop_r),
        .seg    (hex0_o)
    );

endmodule
